// File: rtl/field_packer_pkg.sv
// Shared types and helpers for the field packer.
// FIFO entries carry FP_MAX_W data bits, so the packer supports OUT_W up to FP_MAX_W.
package field_packer_pkg;

   localparam int unsigned FP_MAX_W  = 64;
   localparam int unsigned FP_BITS_W = $clog2(FP_MAX_W + 1);

   typedef enum logic {
      ACCUM = 1'b0,
      FLUSH = 1'b1
   } fp_state_t;

   typedef struct packed {
      logic [FP_MAX_W-1:0]  data;
      logic [FP_BITS_W-1:0] bits;
      logic                 last;
   } fp_entry_t;

   // Field length with anything above the maximum field width clamped to it.
   function automatic int unsigned fp_clamp_len(input int unsigned len, input int unsigned max_w);
      return (len > max_w) ? max_w : len;
   endfunction

endpackage

// File: rtl/field_packer_fifo.sv
// Circular-buffer FIFO holding packed output words; DEPTH need not be a power of two.
module field_packer_fifo
   import field_packer_pkg::*;
#(
   parameter int unsigned W     = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic [W-1:0]                 i_data,
   input  logic                         i_pop,
   output logic [W-1:0]                 o_data,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_valid
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr;
   logic [PW-1:0] r_rd;
   logic [CW-1:0] r_count;
   logic          w_push;
   logic          w_pop;

   function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign w_pop   = i_pop && (r_count != '0);
   assign w_push  = i_push && (r_count != CW'(DEPTH));
   assign o_valid = (r_count != '0);
   assign o_count = r_count;
   assign o_data  = o_valid ? r_mem[r_rd] : '0;

   // Storage array: written on push only, never reset (reads are gated by o_valid).
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= i_data;
   end

   // Pointers and occupancy; push with pop leaves the count unchanged.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wr <= f_next(r_wr);
         if (w_pop)  r_rd <= f_next(r_rd);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/field_packer.sv
// Variable-length field packer: accumulates 0..IN_W-bit fields into OUT_W-bit words,
// flushes a partial word at packet end, and buffers words in a DEPTH-entry FIFO.
// Define FIELD_PACKER_MSB_FIRST_EN to pack fields MSB-first (left-aligned words).
module field_packer
   import field_packer_pkg::*;
#(
   parameter int unsigned OUT_W = 32,
   parameter int unsigned IN_W  = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [IN_W-1:0]             in_data,
   input  logic [$clog2(IN_W+1)-1:0]   in_len,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [OUT_W-1:0]            out_data,
   output logic [$clog2(OUT_W+1)-1:0]  out_bits,
   output logic                        out_last
);

   localparam int unsigned LW = $clog2(IN_W + 1);
   localparam int unsigned BW = $clog2(OUT_W + 1);
   localparam int unsigned AW = OUT_W + IN_W;
   localparam int unsigned FW = $clog2(AW + 1);
   localparam int unsigned IW = $clog2(AW);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned EW = $bits(fp_entry_t);
`ifdef FIELD_PACKER_MSB_FIRST_EN
   localparam int unsigned WORD_LSB = AW - OUT_W;
`else
   localparam int unsigned WORD_LSB = 0;
`endif

   fp_state_t      r_state;
   fp_state_t      w_state_n;
   logic [AW-1:0]  r_acc;
   logic [AW-1:0]  w_acc_n;
   logic [AW-1:0]  w_acc_ins;
   logic [BW-1:0]  r_fill;
   logic [BW-1:0]  w_fill_n;
   logic [LW-1:0]  w_len;
   logic [IN_W:0]  w_one_hot;
   logic [IN_W-1:0] w_mask;
   logic [IN_W-1:0] w_field;
   logic [FW-1:0]  w_fill_sum;
   logic [FW-1:0]  w_rem;
   logic [IW-1:0]  w_pos;
   logic           w_space;
   logic           w_accept;
   logic           w_push;
   logic           w_pop;
   fp_entry_t      w_push_e;
   fp_entry_t      w_head;
   logic [CW-1:0]  w_count;
   logic           w_unused;

   assign w_space  = (w_count < CW'(DEPTH));
   assign in_ready = !rst && (r_state == ACCUM) && w_space;
   assign w_accept = in_valid && in_ready;
   assign w_pop    = out_valid && out_ready;

   // Field conditioning: clamp length, mask stray high bits, place into the accumulator.
   always_comb begin
      w_len      = LW'(fp_clamp_len(32'(in_len), IN_W));
      w_one_hot  = (IN_W+1)'(1) << w_len;
      w_mask     = IN_W'(w_one_hot - (IN_W+1)'(1));
      w_field    = in_data & w_mask;
      w_fill_sum = FW'(r_fill) + FW'(w_len);
      w_acc_ins  = r_acc;
`ifdef FIELD_PACKER_MSB_FIRST_EN
      w_field    = w_field << (LW'(IN_W) - w_len);
      w_pos      = IW'(AW - 1) - IW'(r_fill);
      w_acc_ins[w_pos -: IN_W] = w_field;
`else
      w_pos      = IW'(r_fill);
      w_acc_ins[w_pos +: IN_W] = w_field;
`endif
   end

   // Next-state logic: word completion, residue flush, FIFO push request.
   always_comb begin
      w_state_n = r_state;
      w_acc_n   = r_acc;
      w_fill_n  = r_fill;
      w_rem     = w_fill_sum;
      w_push    = 1'b0;
      w_push_e  = '0;
      case (r_state)
         ACCUM: begin
            if (w_accept) begin
               w_acc_n = w_acc_ins;
               if (w_fill_sum >= FW'(OUT_W)) begin
                  w_push        = 1'b1;
                  w_push_e.data = FP_MAX_W'(w_acc_ins[WORD_LSB +: OUT_W]);
                  w_push_e.bits = FP_BITS_W'(OUT_W);
                  w_push_e.last = in_last && (w_fill_sum == FW'(OUT_W));
`ifdef FIELD_PACKER_MSB_FIRST_EN
                  w_acc_n       = w_acc_ins << OUT_W;
`else
                  w_acc_n       = w_acc_ins >> OUT_W;
`endif
                  w_rem         = w_fill_sum - FW'(OUT_W);
               end
               w_fill_n = BW'(w_rem);
               if (in_last) begin
                  if (w_rem != '0) begin
                     w_state_n = FLUSH;
                  end else begin
                     w_acc_n  = '0;
                     w_fill_n = '0;
                  end
               end
            end
         end
         FLUSH: begin
            if (w_space) begin
               w_push        = 1'b1;
               w_push_e.data = FP_MAX_W'(r_acc[WORD_LSB +: OUT_W]);
               w_push_e.bits = FP_BITS_W'(r_fill);
               w_push_e.last = 1'b1;
               w_acc_n       = '0;
               w_fill_n      = '0;
               w_state_n     = ACCUM;
            end
         end
         default: w_state_n = ACCUM;
      endcase
   end

   // State, accumulator and fill registers; reset discards any residue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ACCUM;
         r_acc   <= '0;
         r_fill  <= '0;
      end else begin
         r_state <= w_state_n;
         r_acc   <= w_acc_n;
         r_fill  <= w_fill_n;
      end
   end

   field_packer_fifo #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_data  (w_push_e),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_count (w_count),
      .o_valid (out_valid)
   );

   assign out_data = w_head.data[OUT_W-1:0];
   assign out_bits = w_head.bits[BW-1:0];
   assign out_last = w_head.last;
   assign w_unused = ^{w_head.data, w_head.bits};

endmodule

// File: tb/tb_field_packer.sv
// Self-checking bench for field_packer (OUT_W=32, IN_W=8, DEPTH=4).
// Reference model is a bit queue: fields append bits, 32 bits make a word,
// packet end flushes the remainder. Honours FIELD_PACKER_MSB_FIRST_EN.
module tb_field_packer;

   localparam int unsigned OUT_W = 32;
   localparam int unsigned IN_W  = 8;
   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [7:0]  in_data = '0;
   logic [3:0]  in_len = '0;
   logic        in_last = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [5:0]  out_bits;
   logic        out_last;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;
   bit rand_rdy = 1'b0;

   typedef struct {
      logic [31:0] d;
      int          b;
      bit          l;
   } exp_t;

   exp_t eq[$];
   bit   bq[$];
   exp_t e_m;

   always #5 clk = ~clk;

   field_packer #(
      .OUT_W (OUT_W),
      .IN_W  (IN_W),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_len    (in_len),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_bits  (out_bits),
      .out_last  (out_last)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic emit(input int n, input bit last);
      logic [31:0] w;
      bit b;
      w = '0;
      for (int i = 0; i < n; i++) begin
         b = bq.pop_front();
`ifdef FIELD_PACKER_MSB_FIRST_EN
         w[31-i] = b;
`else
         w[i] = b;
`endif
      end
      eq.push_back('{w, n, last});
   endtask

   task automatic model_beat(input logic [7:0] d, input logic [3:0] len, input bit last);
      int l;
      l = (len > 4'd8) ? 8 : int'(len);
      for (int i = 0; i < l; i++) begin
`ifdef FIELD_PACKER_MSB_FIRST_EN
         bq.push_back(d[l-1-i]);
`else
         bq.push_back(d[i]);
`endif
      end
      if (bq.size() >= 32) emit(32, last && (bq.size() == 32));
      if (last && (bq.size() > 0)) emit(bq.size(), 1'b1);
   endtask

   // Scoreboard: sample handshakes mid-cycle, compare popped words, feed accepted beats to the model.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready) begin
            n_checks++;
            assert (eq.size() != 0) else begin
               n_fail++;
               $error("FAIL unexpected_word: observed %h expected no word", out_data);
            end
            if (eq.size() != 0) begin
               e_m = eq.pop_front();
               check("word_data", 64'(out_data), 64'(e_m.d));
               check("word_bits", 64'(out_bits), 64'(e_m.b));
               check("word_last", 64'(out_last), 64'(e_m.l));
               n_pops++;
            end
         end
         if (in_valid && in_ready) model_beat(in_data, in_len, in_last);
      end
   end

   // Random downstream backpressure while enabled.
   always @(posedge clk) begin
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
   end

   // Present one beat (called at posedge+1) and hold it until accepted.
   task automatic send(input logic [7:0] d, input logic [3:0] l, input bit last);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_len   = l;
      in_last  = last;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!in_ready && n < 200);
      if (!in_ready) check("send_timeout_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_out(output int cyc);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!out_valid && cyc < 50);
   endtask

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int k;
      k = 0;
      while ((eq.size() != 0 || out_valid) && k < 300) begin
         @(negedge clk);
         k++;
      end
      check({tag, "_queue_empty"}, 64'(eq.size()), 64'(0));
      check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
      check({tag, "_out_data"},  64'(out_data),  64'(0));
      check({tag, "_out_bits"},  64'(out_bits),  64'(0));
      check({tag, "_out_last"},  64'(out_last),  64'(0));
      check({tag, "_in_ready"},  64'(in_ready),  64'(0));
   endtask

   initial begin
      int c;
      int p0;
      logic [31:0] exp_t1, exp_t2, exp_t3b;
`ifdef FIELD_PACKER_MSB_FIRST_EN
      exp_t1  = 32'h11223344;
      exp_t2  = 32'hABA00000;
      exp_t3b = 32'hFC000000;
`else
      exp_t1  = 32'h44332211;
      exp_t2  = 32'h000005BA;
      exp_t3b = 32'h0000003F;
`endif

      // Reset state
      #1;
      check_idle_outputs("reset");
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      align();
      out_ready = 1'b1;

      // Empty packet: len 0 with last produces nothing
      send(8'hFF, 4'd0, 1'b1);
      repeat (3) @(negedge clk);
      check("empty_pkt_no_word", 64'(out_valid), 64'(0));
      align();

      // Four full fields, exact word, no flush
      send(8'h11, 4'd8, 1'b0);
      send(8'h22, 4'd8, 1'b0);
      send(8'h33, 4'd8, 1'b0);
      send(8'h44, 4'd8, 1'b1);
      wait_out(c);
      check("t1_latency", 64'(c), 64'(1));
      check("t1_data", 64'(out_data), 64'(exp_t1));
      check("t1_bits", 64'(out_bits), 64'(32));
      check("t1_last", 64'(out_last), 64'(1));
      @(negedge clk);
      check("t1_no_flush_word", 64'(out_valid), 64'(0));
      align();

      // Partial word flushed at packet end, two-cycle latency
      send(8'h0A, 4'd4, 1'b0);
      send(8'h0B, 4'd4, 1'b0);
      send(8'hF5, 4'd3, 1'b1);
      wait_out(c);
      check("t2_latency", 64'(c), 64'(2));
      check("t2_data", 64'(out_data), 64'(exp_t2));
      check("t2_bits", 64'(out_bits), 64'(11));
      check("t2_last", 64'(out_last), 64'(1));
      align();

      // Spill across a word boundary on the last beat, then flush
      repeat (5) send(8'h3F, 4'd6, 1'b0);
      send(8'hFF, 4'd8, 1'b1);
      wait_out(c);
      check("t3_latency", 64'(c), 64'(1));
      check("t3a_data", 64'(out_data), 64'(32'hFFFFFFFF));
      check("t3a_bits", 64'(out_bits), 64'(32));
      check("t3a_last", 64'(out_last), 64'(0));
      @(negedge clk);
      check("t3b_valid", 64'(out_valid), 64'(1));
      check("t3b_data", 64'(out_data), 64'(exp_t3b));
      check("t3b_bits", 64'(out_bits), 64'(6));
      check("t3b_last", 64'(out_last), 64'(1));
      align();

      // Backpressure: FIFO fills at DEPTH words, nothing lost after release
      out_ready = 1'b0;
      p0 = n_pops;
      for (int i = 0; i < 16; i++) send(8'(i * 7 + 1), 4'd8, 1'b0);
      @(negedge clk);
      check("t4_in_ready_full", 64'(in_ready), 64'(0));
      check("t4_out_valid_full", 64'(out_valid), 64'(1));
      align();
      out_ready = 1'b1;
      for (int i = 16; i < 20; i++) send(8'(i * 7 + 1), 4'd8, i == 19);
      drain("t4_drain");
      check("t4_word_count", 64'(n_pops - p0), 64'(5));
      align();

      // Reset with a queued word and 12 residue bits
      out_ready = 1'b0;
      send(8'h11, 4'd8, 1'b0);
      send(8'h22, 4'd8, 1'b0);
      send(8'h33, 4'd8, 1'b0);
      send(8'h44, 4'd8, 1'b0);
      send(8'hAB, 4'd8, 1'b0);
      send(8'h05, 4'd4, 1'b0);
      in_valid = 1'b1;
      in_data  = 8'h77;
      in_len   = 4'd8;
      #2;
      rst = 1'b1;
      bq.delete();
      eq.delete();
      #1;
      check_idle_outputs("t5_rst");
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      rst = 1'b0;
      align();
      out_ready = 1'b1;
      send(8'h11, 4'd8, 1'b0);
      send(8'h22, 4'd8, 1'b0);
      send(8'h33, 4'd8, 1'b0);
      send(8'h44, 4'd8, 1'b1);
      wait_out(c);
      check("t5_data", 64'(out_data), 64'(exp_t1));
      check("t5_bits", 64'(out_bits), 64'(32));
      check("t5_last", 64'(out_last), 64'(1));
      drain("t5_drain");
      align();

      // Random fields (lengths 0..15 exercise clamping) with random backpressure
      rand_rdy = 1'b1;
      for (int i = 0; i < 120; i++) begin
         send(8'($urandom), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 5) == 0) || (i == 119));
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #2;
      out_ready = 1'b1;
      drain("rand_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
